// File: rtl/prog_fetch.sv
// prog_fetch: instruction fetch unit sitting on the read side of a small
// program memory (combinational read). It owns the program counter, registers
// each fetched word into the instruction register (IR), and hands the IR to
// the decoder over a valid/ready handshake. Decoder jumps flush the IR and
// redirect the PC. A HALT opcode stops fetching once the decoder has taken it.
// A resume pulse then restarts fetching just past the halt word.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous active-high reset
//   pm_adr    out  AW  program memory address (always the PC)
//   pm_data   in   DW  program memory read data (same cycle as pm_adr)
//   ir        out  DW  instruction register
//   ir_valid  out  1   ir holds an unconsumed instruction
//   ir_ready  in   1   decoder accepts ir this cycle
//   jmp_en    in   1   one-cycle jump request
//   jmp_adr   in   AW  jump target (sampled only with jmp_en)
//   resume    in   1   restart pulse, honoured only while halted
//   halted    out  1   unit is in HALT
//   pc_out    out  AW  current PC for debug
module prog_fetch #(
  parameter int              AW      = 5,
  parameter int              DW      = 6,
  parameter logic [DW-1:0]   HALT_OP = {DW{1'b1}},
  parameter logic [AW-1:0]   RST_PC  = {AW{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] pm_adr,
  input  logic [DW-1:0] pm_data,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_adr,
  input  logic          resume,
  output logic          halted,
  output logic [AW-1:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          halted_q, halted_d;
  logic          load_s;

  // Next-state logic: jump beats everything, then load/accept, else hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    // An empty IR, or one being accepted this cycle, can be refilled; this is
    // what gives one instruction per cycle under continuous ready.
    load_s     = (state_q == S_RUN) && (!ir_valid_q || ir_ready) && !jmp_en;

    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (jmp_en) begin
          pc_d       = jmp_adr;
          ir_valid_d = 1'b0;
        end else if (load_s) begin
          ir_d       = pm_data;
          ir_valid_d = 1'b1;
          if (pm_data == HALT_OP) begin
            // PC stays on the halt word; resume steps past it.
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end else begin
          // Stall: IR must stay stable while valid and unaccepted.
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (jmp_en) begin
          pc_d       = jmp_adr;
          ir_valid_d = 1'b0;
          state_d    = S_RUN;
        end else if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_HALT;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_HALT: begin
        ir_valid_d = 1'b0;
        if (resume) begin
          pc_d    = pc_q + PC_ONE;
          state_d = S_RUN;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d    = S_IDLE;
        ir_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d == S_HALT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RST_PC;
      ir_q       <= {DW{1'b0}};
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign pm_adr   = pc_q;
  assign pc_out   = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_prog_fetch.sv
module tb_prog_fetch;

  logic       clk;
  logic       rst;
  logic [4:0] pm_adr;
  logic [5:0] pm_data;
  logic [5:0] ir;
  logic       ir_valid;
  logic       ir_ready;
  logic       jmp_en;
  logic [4:0] jmp_adr;
  logic       resume;
  logic       halted;
  logic [4:0] pc_out;

  logic [5:0] mem [32];
  int total;
  int bad;

  // One vector: inputs applied before an edge, expected outputs after it.
  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       jmp;
    logic [4:0] jadr;
    logic       res;
    logic       eh;
    logic       ev;
    logic [5:0] ei;
    logic [4:0] ep;
  } vec_t;

  prog_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .pm_adr   (pm_adr),
    .pm_data  (pm_data),
    .ir       (ir),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .jmp_en   (jmp_en),
    .jmp_adr  (jmp_adr),
    .resume   (resume),
    .halted   (halted),
    .pc_out   (pc_out)
  );

  assign pm_data = mem[pm_adr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic r, input logic rdy, input logic j,
                               input logic [4:0] ja, input logic rs,
                               input logic eh, input logic ev,
                               input logic [5:0] ei, input logic [4:0] ep);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.jmp = j; v.jadr = ja; v.res = rs;
    v.eh = eh; v.ev = ev; v.ei = ei; v.ep = ep;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; ir_ready = v.rdy; jmp_en = v.jmp; jmp_adr = v.jadr; resume = v.res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    // Reset must win over every other input.
    q.push_back(mkv(1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL reset[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      total++;
      if (ir !== q[k].ei) begin
        bad++;
        $display("FAIL reset[%0d] ir got %0d need %0d", k, ir, q[k].ei);
      end
    end
  endtask

  task automatic test_startup();
    vec_t q[$];
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd3, 5'd3));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4, 5'd4));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL startup[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL startup[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t q[$];
    q.push_back(mkv(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2));
    // Three stall cycles; resume in RUN must be ignored.
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2));
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 6'd2, 5'd2));
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd2, 5'd2));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd3, 5'd3));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd4, 5'd4));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL backpressure[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev || q[k].rst) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL backpressure[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
  endtask

  task automatic test_jump();
    vec_t q[$];
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'd4,  5'd4));
    q.push_back(mkv(1'b0, 1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 1'b0, 6'd0,  5'd20));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'd21, 5'd21));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL jump[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL jump[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
  endtask

  task automatic test_wrap();
    vec_t q[$];
    mem[30] = 6'd5; mem[31] = 6'd6; mem[0] = 6'd7;
    q.push_back(mkv(1'b0, 1'b1, 1'b1, 5'd30, 1'b0, 1'b0, 1'b0, 6'd0, 5'd30));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'd5, 5'd31));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'd6, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'd7, 5'd1));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL wrap[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL wrap[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
    mem[0] = 6'd1;
  endtask

  task automatic test_halt();
    vec_t q[$];
    mem[6] = 6'h3f;
    q.push_back(mkv(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    for (int i = 1; i <= 6; i++) begin
      q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'(i), 5'(i)));
    end
    // Halt word loaded: PC stays on it.
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'h3f, 5'd6));
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'h3f, 5'd6));
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'h3f, 5'd6));
    // Accept: halted one edge later.
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'd0, 5'd6));
    // Jump ignored in HALT.
    q.push_back(mkv(1'b0, 1'b1, 1'b1, 5'd20, 1'b0, 1'b1, 1'b0, 6'd0, 5'd6));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 5'd7));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd8, 5'd8));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL halt[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL halt[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
  endtask

  task automatic test_reset_in_drain();
    vec_t q[$];
    q.push_back(mkv(1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    for (int i = 1; i <= 6; i++) begin
      q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'(i), 5'(i)));
    end
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'h3f, 5'd6));
    q.push_back(mkv(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'h3f, 5'd6));
    // Reset while draining with an unconsumed halt word.
    q.push_back(mkv(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0));
    q.push_back(mkv(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 6'd1, 5'd1));
    foreach (q[k]) begin
      apply(q[k]); step();
      total++;
      if ({halted, ir_valid, pc_out, pm_adr} !== {q[k].eh, q[k].ev, q[k].ep, q[k].ep}) begin
        bad++;
        $display("FAIL rst_drain[%0d] h/v/pc/adr got %b/%b/%0d/%0d need %b/%b/%0d", k, halted, ir_valid, pc_out, pm_adr, q[k].eh, q[k].ev, q[k].ep);
      end
      if (q[k].ev || q[k].rst) begin
        total++;
        if (ir !== q[k].ei) begin
          bad++;
          $display("FAIL rst_drain[%0d] ir got %0d need %0d", k, ir, q[k].ei);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) mem[i] = 6'(i + 1);
    rst = 1'b1; ir_ready = 1'b0; jmp_en = 1'b0; jmp_adr = 5'd0; resume = 1'b0;
    test_reset();
    test_startup();
    test_backpressure();
    test_jump();
    test_wrap();
    test_halt();
    test_reset_in_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
